addsub_tree: RTL and testbench

- Parametrised, pipelined multi-operand add/subtract in signed two's complement fixed point: f = sum over i of (±x[i]).
- The sign of each operand is chosen at run time by a per-operand subtract mask.
- Builds a registered adder tree with valid tracking, clock enable, and optional saturation with overflow flags.
- Sits in the matrix datapath wherever chains of add/sub operators were previously hand-instantiated.

---
 rtl/addsub_tree_if.sv | 19 +
 rtl/addsub_tree.sv | 101 ++++++++++
 tb/tb_addsub_tree.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_tree_if.sv
// Fixed-point datapath bundle: shared clock, reset and word width.
// Every fixedp unit takes its operand width from here.
package fixedp_pkg;
  localparam int WIDTH = 8;
endpackage

interface fixedp (input logic clk);
  logic reset;

  modport master (
    input  clk,
    output reset
  );

  modport slave (
    input clk,
    input reset
  );
endinterface

// File: rtl/addsub_tree.sv
// Pipelined multi-operand add/sub tree: f = sum(+/-x[i]).
// Exact internal width; optional output saturation with overflow flags.
module addsub_tree
  import fixedp_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter bit SAT    = 1'b0
) (
  fixedp.slave                   g,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [NUM_IN*WIDTH-1:0] x,
  input  logic [NUM_IN-1:0]      sub,
  input  logic                   ovf_clr,
  output logic [WIDTH-1:0]       f,
  output logic                   out_valid,
  output logic                   ovf,
  output logic                   ovf_sticky
);

  localparam int L  = (NUM_IN > 1) ? $clog2(NUM_IN) : 0;
  localparam int N2 = 1 << L;
  localparam int IW = WIDTH + L + 1;

  localparam logic signed [IW-1:0] MAXV =
    {{(L+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] MINV =
    {{(L+2){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [IW-1:0] opw [N2];

  for (genvar i = 0; i < N2; i++) begin : g_op
    if (i < NUM_IN) begin : g_live
      logic signed [IW-1:0] ext;
      assign ext = {{(IW-WIDTH){x[i*WIDTH+WIDTH-1]}},
                    x[i*WIDTH +: WIDTH]};
      assign opw[i] = sub[i] ? -ext : ext;
    end else begin : g_pad
      assign opw[i] = '0;
    end
  end

  // Heap layout: leaves at N2-1.., node n sums 2n+1 and 2n+2,
  // so each tree level lands one register further from the leaves.
  logic signed [IW-1:0] tr [2*N2-1];

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      for (int n = 0; n < 2*N2-1; n++) begin
        tr[n] <= '0;
      end
    end else if (en) begin
      for (int n = 0; n < N2-1; n++) begin
        tr[n] <= tr[2*n+1] + tr[2*n+2];
      end
      for (int i = 0; i < N2; i++) begin
        tr[N2-1+i] <= opw[i];
      end
    end
  end

  logic signed [IW-1:0] sum;
  logic                 pos;
  logic                 neg;
  logic [WIDTH-1:0]     fn;
  logic [L+1:0]         vp;

  assign sum = tr[0];
  assign pos = sum > MAXV;
  assign neg = sum < MINV;

  always_comb begin
    fn = sum[WIDTH-1:0];
    if (SAT && pos) begin
      fn = MAXV[WIDTH-1:0];
    end else if (SAT && neg) begin
      fn = MINV[WIDTH-1:0];
    end
  end

  always_ff @(posedge g.clk) begin
    if (g.reset) begin
      vp         <= '0;
      f          <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (en) begin
        vp  <= {vp[L:0], in_valid};
        f   <= fn;
        ovf <= pos | neg;
      end
      // a fresh overflow beats a simultaneous clear
      ovf_sticky <= (ovf_sticky & ~ovf_clr)
                  | (en & vp[L] & (pos | neg));
    end
  end

  assign out_valid = vp[L+1];

endmodule

// File: tb/tb_addsub_tree.sv
// Scoreboard bench for addsub_tree across four configurations
// (4 wrap, 4 saturate, 3 wrap, 1 wrap) sharing one fixedp bundle.
module tb_addsub_tree;

  typedef struct {
    logic [7:0] f;
    logic       o;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  fixedp g (.clk(clk));

  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [31:0] x4 = '0;
  logic [3:0]  s4 = '0;
  logic [23:0] x3 = '0;
  logic [2:0]  s3 = '0;
  logic [7:0]  x1 = '0;
  logic [0:0]  s1 = '0;

  logic [7:0] fo [4];
  logic       vo [4];
  logic       oo [4];
  logic       so [4];

  addsub_tree #(.NUM_IN(4), .SAT(1'b0)) u_4w (
    .g(g), .en(en), .in_valid(in_valid), .x(x4), .sub(s4),
    .ovf_clr(ovf_clr), .f(fo[0]), .out_valid(vo[0]),
    .ovf(oo[0]), .ovf_sticky(so[0])
  );

  addsub_tree #(.NUM_IN(4), .SAT(1'b1)) u_4s (
    .g(g), .en(en), .in_valid(in_valid), .x(x4), .sub(s4),
    .ovf_clr(ovf_clr), .f(fo[1]), .out_valid(vo[1]),
    .ovf(oo[1]), .ovf_sticky(so[1])
  );

  addsub_tree #(.NUM_IN(3), .SAT(1'b0)) u_3w (
    .g(g), .en(en), .in_valid(in_valid), .x(x3), .sub(s3),
    .ovf_clr(ovf_clr), .f(fo[2]), .out_valid(vo[2]),
    .ovf(oo[2]), .ovf_sticky(so[2])
  );

  addsub_tree #(.NUM_IN(1), .SAT(1'b0)) u_1w (
    .g(g), .en(en), .in_valid(in_valid), .x(x1), .sub(s1),
    .ovf_clr(ovf_clr), .f(fo[3]), .out_valid(vo[3]),
    .ovf(oo[3]), .ovf_sticky(so[3])
  );

  int   nchk = 0;
  int   nerr = 0;
  int   ecnt = 0;
  int   lat [4] = '{4, 4, 4, 2};
  exp_t sb [4][$];

  logic [7:0] lf  [4];
  logic       lv  [4];
  logic       lo  [4];
  logic       mst [4];

  task automatic check(input string tag, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[dut%0d] t=%0t: got %0h want %0h",
               tag, d, $time, act, exp);
    end
  endtask

  function automatic exp_t mdl(input int d, input int due);
    int          n;
    bit          sat;
    logic [31:0] xv;
    logic [3:0]  sv;
    int          s;
    int          xi;
    exp_t        e;
    n = 4; sat = 1'b0; xv = x4; sv = s4;
    case (d)
      1: sat = 1'b1;
      2: begin n = 3; xv = {8'h0, x3}; sv = {1'b0, s3}; end
      3: begin n = 1; xv = {24'h0, x1}; sv = {3'b0, s1}; end
      default: ;
    endcase
    s = 0;
    for (int i = 0; i < n; i++) begin
      xi = int'($signed(xv[i*8 +: 8]));
      s += sv[i] ? -xi : xi;
    end
    e.o = (s > 127) || (s < -128);
    e.f = s[7:0];
    if (sat && s > 127)  e.f = 8'h7f;
    if (sat && s < -128) e.f = 8'h80;
    e.due = due;
    return e;
  endfunction

  always @(posedge clk) begin : mon
    bit   rs;
    bit   ena;
    bit   ev [4];
    exp_t e;
    rs  = g.reset;
    ena = en;
    if (rs) begin
      for (int d = 0; d < 4; d++) sb[d].delete();
    end else if (ena) begin
      ecnt++;
      if (in_valid) begin
        for (int d = 0; d < 4; d++)
          sb[d].push_back(mdl(d, ecnt + lat[d] - 1));
      end
    end
    for (int d = 0; d < 4; d++) begin
      ev[d] = !rs && ena && (sb[d].size() > 0)
              && (sb[d][0].due == ecnt);
      if (rs) mst[d] = 1'b0;
      else    mst[d] = (mst[d] & ~ovf_clr) | (ev[d] & sb[d][0].o);
    end
    #1;
    for (int d = 0; d < 4; d++) begin
      if (rs) begin
        check("rst_valid", d, 32'(vo[d]), 32'd0);
        check("rst_f",     d, 32'(fo[d]), 32'd0);
        check("rst_ovf",   d, 32'(oo[d]), 32'd0);
        lv[d] = 1'b0;
      end else if (ena) begin
        check("valid", d, 32'(vo[d]), 32'(ev[d]));
        if (ev[d]) begin
          e = sb[d].pop_front();
          check("f",   d, 32'(fo[d]), 32'(e.f));
          check("ovf", d, 32'(oo[d]), 32'(e.o));
          lv[d] = 1'b1; lf[d] = e.f; lo[d] = e.o;
        end else begin
          lv[d] = 1'b0;
        end
      end else begin
        check("hold_valid", d, 32'(vo[d]), 32'(lv[d]));
        if (lv[d]) begin
          check("hold_f",   d, 32'(fo[d]), 32'(lf[d]));
          check("hold_ovf", d, 32'(oo[d]), 32'(lo[d]));
        end
      end
      check("sticky", d, 32'(so[d]), 32'(mst[d]));
    end
  end

  task automatic drv(input bit r, input bit e, input bit v,
                     input bit c,
                     input logic [31:0] a4, input logic [3:0] b4,
                     input logic [23:0] a3, input logic [2:0] b3,
                     input logic [7:0] a1, input logic b1);
    @(negedge clk);
    g.reset = r; en = e; in_valid = v; ovf_clr = c;
    x4 = a4; s4 = b4; x3 = a3; s3 = b3; x1 = a1; s1 = b1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 1, 0, 0, '0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic ovf_smp();
    drv(0, 1, 1, 0, {8'd0, 8'hce, 8'h9c, 8'd100}, 4'b1110,
        {8'h80, 8'h80, 8'h80}, 3'b000, 8'h80, 1'b1);
  endtask

  initial begin
    g.reset = 1'b1;
    drv(1, 1, 0, 0, '0, '0, '0, '0, '0, 1'b0);
    drv(1, 1, 0, 0, '0, '0, '0, '0, '0, 1'b0);
    // basic subtract, odd count, single operand
    drv(0, 1, 1, 0, {8'd1, 8'd2, 8'd3, 8'd10}, 4'b1110,
        {8'hfe, 8'd7, 8'd5}, 3'b010, 8'd9, 1'b1);
    idle(6);
    // wrap / positive saturate, then negative and +128 corners
    ovf_smp();
    drv(0, 1, 1, 0, {8'd127, 8'd127, 8'd127, 8'h80}, 4'b1110,
        {8'h80, 8'h80, 8'h7f}, 3'b011, 8'h7f, 1'b0);
    drv(0, 1, 1, 0, {8'd0, 8'd0, 8'd0, 8'h80}, 4'b0001,
        {8'h00, 8'h00, 8'h80}, 3'b001, 8'h80, 1'b0);
    idle(6);
    // back-to-back with en pattern 1,1,0,1,0,1,...
    for (int k = 0; k < 10; k++) begin
      drv(0, (k < 2) || (k % 2 == 1), 1, 0, $urandom,
          4'($urandom), 24'($urandom), 3'($urandom),
          8'($urandom), 1'($urandom));
    end
    idle(1);
    drv(0, 0, 0, 0, '0, '0, '0, '0, '0, 1'b0);
    idle(1);
    drv(0, 0, 1, 0, $urandom, 4'hf, '0, '0, '0, 1'b0);
    idle(6);
    // reset while two samples are in flight
    drv(0, 1, 1, 0, $urandom, 4'($urandom), 24'($urandom),
        3'($urandom), 8'($urandom), 1'($urandom));
    ovf_smp();
    idle(1);
    drv(1, 1, 1, 0, $urandom, '0, '0, '0, '0, 1'b0);
    drv(0, 1, 1, 0, {8'd1, 8'd2, 8'd3, 8'd10}, 4'b1110,
        {8'hfe, 8'd7, 8'd5}, 3'b010, 8'd9, 1'b1);
    idle(6);
    // clear racing a new overflow, then clear alone
    ovf_smp();
    ovf_smp();
    idle(2);
    drv(0, 1, 0, 1, '0, '0, '0, '0, '0, 1'b0);
    drv(0, 1, 0, 1, '0, '0, '0, '0, '0, 1'b0);
    idle(4);
    for (int d = 0; d < 4; d++)
      check("drain", d, 32'(sb[d].size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
